// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between byte producers, the TX FIFO and the UART transmitter.
// master = producer/transmitter side, slave = FIFO side.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             flush;
    logic             overflow;
    logic [AW:0]      count;

    modport master (
        output wr_data, wr_valid, rd_ready, flush,
        input  wr_ready, rd_data, rd_valid, overflow, count
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready, flush,
        output wr_ready, rd_data, rd_valid, overflow, count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter.
// Define UART_TX_FIFO_OVERWRITE_EN to drop the oldest byte instead of refusing when full.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, push, pop;

    always_comb begin
        full = (count_q == FULL_CNT);
`ifdef UART_TX_FIFO_OVERWRITE_EN
        bus.wr_ready = ~bus.flush;
`else
        bus.wr_ready = ~full & ~bus.flush;
`endif
        push = bus.wr_valid & bus.wr_ready;
        pop  = (count_q != '0) & bus.rd_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
`ifdef UART_TX_FIFO_OVERWRITE_EN
            // Write into a full FIFO with no pop evicts the oldest byte
            if (push && full && !pop) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
                ovf_d    = 1'b1;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
                count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
            end
`else
            if (bus.wr_valid && full) ovf_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data  = mem_q[rd_ptr_q];
    assign bus.rd_valid = (count_q != '0);
    assign bus.overflow = ovf_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo.
// Expected bytes are queued on accepted writes and compared on pops.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 8'(i);
            exp_q.push_back(base + 8'(i));
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0 ||
            bus.overflow !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got v=%b cnt=%0d ovf=%b wr=%b exp v=0 cnt=0 ovf=0 wr=1",
                     bus.rd_valid, bus.count, bus.overflow, bus.wr_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h4D;
        exp_q.push_back(8'h4D);
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h4D || bus.count !== 5'd1) begin
            errors++;
            $display("FAIL single_wr got v=%b d=%h cnt=%0d exp v=1 d=4d cnt=1",
                     bus.rd_valid, bus.rd_data, bus.count);
        end
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== exp_b) begin
            errors++;
            $display("FAIL single_pop_data got %h exp %h", bus.rd_data, exp_b);
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL single_empty got v=%b cnt=%0d exp v=0 cnt=0",
                     bus.rd_valid, bus.count);
        end
    endtask

    task automatic test_fill_overflow();
        fill(16, 8'h00);
        checks++;
        if (bus.count !== 5'd16 || bus.wr_ready !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full got cnt=%0d wr=%b ovf=%b exp cnt=16 wr=0 ovf=0",
                     bus.count, bus.wr_ready, bus.overflow);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hAA;
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL refuse got ovf=%b cnt=%0d exp ovf=1 cnt=16",
                     bus.overflow, bus.count);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL drain_full[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, bus.rd_valid, bus.rd_data, exp_b);
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky got v=%b cnt=%0d ovf=%b exp v=0 cnt=0 ovf=1",
                     bus.rd_valid, bus.count, bus.overflow);
        end
        do_flush();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", bus.overflow);
        end
    endtask

    task automatic test_stream();
        fill(8, 8'h80);
        for (int i = 0; i < 40; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL stream[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, bus.rd_valid, bus.rd_data, exp_b);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h20 + 8'(i);
            bus.rd_ready = 1'b1;
            exp_q.push_back(8'h20 + 8'(i));
            tick();
            checks++;
            if (bus.count !== 5'd8) begin
                errors++;
                $display("FAIL stream_cnt[%0d] got %0d exp 8", i, bus.count);
            end
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL stream_tail[%0d] got %h exp %h", i, bus.rd_data, exp_b);
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty got v=%b exp 0", bus.rd_valid);
        end
    endtask

    task automatic test_full_simul();
        fill(16, 8'h30);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== exp_b) begin
            errors++;
            $display("FAIL simul_head got %h exp %h", bus.rd_data, exp_b);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        bus.rd_ready = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.count !== 5'd15 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL simul_full got cnt=%0d ovf=%b exp cnt=15 ovf=1",
                     bus.count, bus.overflow);
        end
        for (int i = 0; i < 15; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL simul_drain[%0d] got %h exp %h", i, bus.rd_data, exp_b);
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;
        do_flush();
    endtask

    task automatic test_flush();
        fill(16, 8'h60);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hAA;
        tick();
        bus.wr_valid = 1'b0;
`ifdef UART_TX_FIFO_OVERWRITE_EN
        void'(exp_q.pop_front());
        exp_q.push_back(8'hAA);
`endif
        for (int i = 0; i < 11; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL pre_flush[%0d] got %h exp %h", i, bus.rd_data, exp_b);
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        checks++;
        if (bus.count !== 5'd5 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush_state got cnt=%0d ovf=%b exp cnt=5 ovf=1",
                     bus.count, bus.overflow);
        end
        bus.flush    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hC3;
        bus.rd_ready = 1'b1;
        tick();
        idle();
        exp_q.delete();
        checks++;
        if (bus.count !== 5'd0 || bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush got cnt=%0d ovf=%b v=%b exp cnt=0 ovf=0 v=0",
                     bus.count, bus.overflow, bus.rd_valid);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_lost got v=%b exp 0", bus.rd_valid);
        end
    endtask

`ifdef UART_TX_FIFO_OVERWRITE_EN
    task automatic test_overwrite();
        fill(16, 8'h00);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h10;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h10);
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovw got cnt=%0d ovf=%b exp cnt=16 ovf=1",
                     bus.count, bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp_b) begin
                errors++;
                $display("FAIL ovw_drain[%0d] got %h exp %h", i, bus.rd_data, exp_b);
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;
        do_flush();
        fill(16, 8'h40);
        void'(exp_q.pop_front());
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        bus.rd_ready = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        idle();
        checks++;
        if (bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovw_simul got cnt=%0d ovf=%b exp cnt=16 ovf=0",
                     bus.count, bus.overflow);
        end
        do_flush();
    endtask
`endif

    task automatic test_async_reset();
        fill(3, 8'hB0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hB3;
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0 ||
            bus.overflow !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst got v=%b cnt=%0d ovf=%b wr=%b exp v=0 cnt=0 ovf=0 wr=1",
                     bus.rd_valid, bus.count, bus.overflow, bus.wr_ready);
        end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL post_rst got v=%b cnt=%0d exp v=0 cnt=0",
                     bus.rd_valid, bus.count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef UART_TX_FIFO_OVERWRITE_EN
        test_overwrite();
`else
        test_fill_overflow();
        test_full_simul();
`endif
        test_stream();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
